qspinor_target_io: RTL and testbench

QSPINOR_TARGET_IO -- requirements
Module: qspinor_target_io

---
 rtl/qspi_pkg.sv | 47 ++++
 rtl/qspi_sync.sv | 36 +++
 rtl/qspinor_target_io.sv | 217 +++++++++++++++++++++
 tb/tb_qspinor_target_io.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// -----------------------------------------------------------------------------
// qspi_pkg
// Shared definitions for the QSPI NOR target I/O block: lane-width encoding,
// frame state encoding, header field sizes and small lane helpers.
// -----------------------------------------------------------------------------
package qspi_pkg;

    // Lane width selector. Code 3 is treated exactly like code 2 (quad).
    typedef enum logic [1:0] {
        WIDTH_X1     = 2'd0,
        WIDTH_X2     = 2'd1,
        WIDTH_X4     = 2'd2,
        WIDTH_X4_ALT = 2'd3
    } width_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DMY  = 3'd3,
        ST_DATA = 3'd4
    } state_e;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 24;
    localparam int HDR_BITS  = CMD_BITS + ADDR_BITS;

    // Number of bits moved per sclk cycle.
    function automatic logic [2:0] lane_count(input width_e w);
        case (w)
            WIDTH_X1: return 3'd1;
            WIDTH_X2: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    // Lanes the target drives during the data phase. Single-lane reads go
    // out on lane 1, as on a classic SPI NOR (IO1 = MISO).
    function automatic logic [3:0] lane_enable(input width_e w);
        case (w)
            WIDTH_X1: return 4'b0010;
            WIDTH_X2: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/qspi_sync.sv
// -----------------------------------------------------------------------------
// qspi_sync
// Multi-stage flip-flop synchronizer for a vector of asynchronous inputs.
//   clk   : system clock
//   rstn  : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous inputs
//   q     : inputs after STAGES flops in the clk domain
// -----------------------------------------------------------------------------
module qspi_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // NOTE: the stage array is a handful of flops, not a RAM, so it is safe
    // (and required here) to reset every element.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, giving a true shift chain.
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/qspinor_target_io.sv
// -----------------------------------------------------------------------------
// qspinor_target_io
// QSPI NOR-style target front end (SPI mode 0). Receives an 8-bit command and
// a 24-bit address over 1/2/4 lanes, waits DMY_CYCLES dummy clocks, then
// streams read bytes from an upstream byte source until chip select rises.
// All serial inputs are oversampled in the clk domain (f_sclk <= f_clk/8).
//   clk, rstn           : system clock, asynchronous active-low reset
//   width               : lane width, sampled at the start of each frame
//   qspi_sclk/csb/mosi  : host clock, chip select (active-low), host lanes
//   qspi_miso, qspi_dir : target lanes and per-lane output enables
//   cmd, addr, hdr_vld  : received header and its one-clk valid pulse
//   rd_rdy, rd_d, rd_req: read byte source handshake (rd_req pops rd_d)
//   underrun            : sticky, a byte was needed while rd_rdy was low
//   busy                : a frame is in progress
// -----------------------------------------------------------------------------
module qspinor_target_io #(
    parameter int DMY_CYCLES  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  width,
    input  logic        qspi_sclk,
    input  logic        qspi_csb,
    input  logic [3:0]  qspi_mosi,
    output logic [3:0]  qspi_miso,
    output logic [3:0]  qspi_dir,
    output logic [7:0]  cmd,
    output logic [23:0] addr,
    output logic        hdr_vld,
    input  logic        rd_rdy,
    input  logic [7:0]  rd_d,
    output logic        rd_req,
    output logic        underrun,
    output logic        busy
);

    import qspi_pkg::*;

    localparam logic [5:0] CMD_END = 6'(CMD_BITS);
    localparam logic [5:0] HDR_END = 6'(HDR_BITS);
    localparam logic [7:0] DMY_N   = 8'(DMY_CYCLES);

    // ------------------------------------------------------------------
    // Synchronization and edge detection
    // ------------------------------------------------------------------
    logic [5:0] sync_q;
    logic       s_sclk, s_csb;
    logic [3:0] s_mosi;
    logic       sclk_q, csb_q;
    logic       sclk_rise, sclk_fall, csb_rise, csb_fall;

    // Synchronizer and edge history reset to 0, so csb looks low out of
    // reset. A host already mid-frame therefore produces no csb fall; the
    // frame is ignored until csb goes high and then low again.
    qspi_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (6)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    ({qspi_sclk, qspi_csb, qspi_mosi}),
        .q    (sync_q)
    );

    assign s_sclk    = sync_q[5];
    assign s_csb     = sync_q[4];
    assign s_mosi    = sync_q[3:0];
    assign sclk_rise =  s_sclk & ~sclk_q;
    assign sclk_fall = ~s_sclk &  sclk_q;
    assign csb_rise  =  s_csb  & ~csb_q;
    assign csb_fall  = ~s_csb  &  csb_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e      state, state_nxt;
    width_e      wid;
    logic [31:0] hdr_sh;     // cmd and addr shift in back to back
    logic [5:0]  bit_cnt;    // header bits received so far
    logic [7:0]  dmy_cnt;
    logic [7:0]  out_byte;   // bits of the current byte not yet presented
    logic [3:0]  out_cnt;    // 0 means the next fall is a byte boundary
    logic        hdr_done;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    logic [2:0]  n_lanes;
    logic [5:0]  cnt_nxt;
    logic [31:0] hdr_sh_nxt;
    logic [7:0]  load_byte, out_src, out_byte_nxt;
    logic [3:0]  miso_nxt, out_cnt_nxt;

    assign n_lanes     = lane_count(wid);
    assign cnt_nxt     = bit_cnt + {3'b000, n_lanes};
    assign load_byte   = rd_rdy ? rd_d : 8'hFF;
    assign out_src     = (out_cnt == 4'd0) ? load_byte : out_byte;
    assign out_cnt_nxt = (out_cnt == 4'd0) ? 4'd8 - {1'b0, n_lanes}
                                           : out_cnt - {1'b0, n_lanes};

    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statements can infer a latch.
        hdr_sh_nxt   = {hdr_sh[27:0], s_mosi};
        miso_nxt     = out_src[7:4];
        out_byte_nxt = {out_src[3:0], 4'b0000};
        case (wid)
            WIDTH_X1: begin
                hdr_sh_nxt   = {hdr_sh[30:0], s_mosi[0]};
                miso_nxt     = {2'b00, out_src[7], 1'b0};
                out_byte_nxt = {out_src[6:0], 1'b0};
            end
            WIDTH_X2: begin
                hdr_sh_nxt   = {hdr_sh[29:0], s_mosi[1:0]};
                miso_nxt     = {2'b00, out_src[7:6]};
                out_byte_nxt = {out_src[5:0], 2'b00};
            end
            default: ;
        endcase
    end

    // Next-state logic. A csb rise wins over any sclk edge seen in the same
    // clk so a frame can always be abandoned.
    always_comb begin
        state_nxt = state;
        hdr_done  = 1'b0;
        if (csb_rise) begin
            state_nxt = ST_IDLE;
        end else if (csb_fall && state == ST_IDLE) begin
            state_nxt = ST_CMD;
        end else if (sclk_rise) begin
            case (state)
                ST_CMD: begin
                    if (cnt_nxt == CMD_END) state_nxt = ST_ADDR;
                end
                ST_ADDR: begin
                    if (cnt_nxt == HDR_END) begin
                        hdr_done  = 1'b1;
                        state_nxt = (DMY_CYCLES == 0) ? ST_DATA : ST_DMY;
                    end
                end
                ST_DMY: begin
                    if (dmy_cnt + 8'd1 == DMY_N) state_nxt = ST_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_q    <= 1'b0;
            csb_q     <= 1'b0;
            wid       <= WIDTH_X1;
            hdr_sh    <= '0;
            bit_cnt   <= '0;
            dmy_cnt   <= '0;
            out_byte  <= '0;
            out_cnt   <= '0;
            qspi_miso <= '0;
            qspi_dir  <= '0;
            cmd       <= '0;
            addr      <= '0;
            hdr_vld   <= 1'b0;
            rd_req    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            sclk_q  <= s_sclk;
            csb_q   <= s_csb;
            hdr_vld <= 1'b0;
            rd_req  <= 1'b0;
            if (csb_rise) begin
                // Release the bus and drop any partially shifted byte.
                qspi_dir  <= '0;
                qspi_miso <= '0;
                out_cnt   <= '0;
            end else if (csb_fall && state == ST_IDLE) begin
                wid      <= width_e'(width);
                hdr_sh   <= '0;
                bit_cnt  <= '0;
                dmy_cnt  <= '0;
                out_cnt  <= '0;
                underrun <= 1'b0;
            end else if (sclk_rise && (state == ST_CMD || state == ST_ADDR)) begin
                hdr_sh  <= hdr_sh_nxt;
                bit_cnt <= cnt_nxt;
                // cmd and addr commit together, so an aborted header leaves
                // both at their previous values.
                if (hdr_done) begin
                    cmd     <= hdr_sh_nxt[HDR_BITS-1 -: CMD_BITS];
                    addr    <= hdr_sh_nxt[ADDR_BITS-1:0];
                    hdr_vld <= 1'b1;
                end
            end else if (sclk_rise && state == ST_DMY) begin
                dmy_cnt <= dmy_cnt + 8'd1;
            end else if (sclk_fall && state == ST_DATA) begin
                qspi_dir  <= lane_enable(wid);
                qspi_miso <= miso_nxt;
                out_byte  <= out_byte_nxt;
                out_cnt   <= out_cnt_nxt;
                if (out_cnt == 4'd0) begin
                    if (rd_rdy) rd_req   <= 1'b1;
                    else        underrun <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_qspinor_target_io.sv
// -----------------------------------------------------------------------------
// tb_qspinor_target_io
// Directed bench for qspinor_target_io. Two instances share the host bus:
// dut0 has no dummy phase, dut8 has eight dummy cycles. Each has its own
// byte source model that pops on rd_req.
// -----------------------------------------------------------------------------
module tb_qspinor_target_io;

    localparam int HALF = 50;   // half sclk period: 5 clk periods

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] width = 2'd0;
    logic       qspi_sclk = 1'b0;
    logic       qspi_csb = 1'b1;
    logic [3:0] qspi_mosi = 4'h0;

    logic [3:0]  miso0, dir0, miso8, dir8;
    logic [7:0]  cmd0, cmd8, rd_d0, rd_d8;
    logic [23:0] addr0, addr8;
    logic        hdr_vld0, hdr_vld8, rd_rdy0, rd_rdy8, rd_req0, rd_req8;
    logic        underrun0, underrun8, busy0, busy8;

    int n_tests = 0;
    int n_fail  = 0;

    // Byte source models: entries fifoX[0..lenX-1] are offered in order.
    logic [7:0] fifo0 [4];
    logic [7:0] fifo8 [4];
    int len0 = 0, base0 = 0, req0 = 0, hdr0 = 0, idx0;
    int len8 = 0, base8 = 0, req8 = 0, hdr8 = 0, idx8;

    assign idx0    = req0 - base0;
    assign idx8    = req8 - base8;
    assign rd_rdy0 = (idx0 < len0);
    assign rd_rdy8 = (idx8 < len8);
    assign rd_d0   = (idx0 >= 0 && idx0 < 4) ? fifo0[idx0[1:0]] : 8'h00;
    assign rd_d8   = (idx8 >= 0 && idx8 < 4) ? fifo8[idx8[1:0]] : 8'h00;

    always @(posedge clk) begin
        if (rd_req0)  req0 <= req0 + 1;
        if (rd_req8)  req8 <= req8 + 1;
        if (hdr_vld0) hdr0 <= hdr0 + 1;
        if (hdr_vld8) hdr8 <= hdr8 + 1;
    end

    always #5 clk = ~clk;

    qspinor_target_io #(.DMY_CYCLES(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rstn(rstn), .width(width),
        .qspi_sclk(qspi_sclk), .qspi_csb(qspi_csb), .qspi_mosi(qspi_mosi),
        .qspi_miso(miso0), .qspi_dir(dir0), .cmd(cmd0), .addr(addr0),
        .hdr_vld(hdr_vld0), .rd_rdy(rd_rdy0), .rd_d(rd_d0), .rd_req(rd_req0),
        .underrun(underrun0), .busy(busy0)
    );

    qspinor_target_io #(.DMY_CYCLES(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rstn(rstn), .width(width),
        .qspi_sclk(qspi_sclk), .qspi_csb(qspi_csb), .qspi_mosi(qspi_mosi),
        .qspi_miso(miso8), .qspi_dir(dir8), .cmd(cmd8), .addr(addr8),
        .hdr_vld(hdr_vld8), .rd_rdy(rd_rdy8), .rd_d(rd_d8), .rd_req(rd_req8),
        .underrun(underrun8), .busy(busy8)
    );

    // Host-side capture at each sclk rise.
    logic [3:0]  cap0, cap8, capd0, capd8, dfirst0, dfirst8;
    logic [31:0] rx0, rx8;

    function automatic logic [3:0] lanes(input logic [3:0] c, input int n);
        if (n == 1)      return {3'b000, c[1]};
        else if (n == 2) return {2'b00, c[1:0]};
        else             return c;
    endfunction

    // One sclk cycle, mode 0: data set up while low, sampled on rise.
    task automatic cyc(input logic [3:0] mo);
        qspi_mosi = mo;
        #HALF;
        qspi_sclk = 1'b1;
        cap0 = miso0; cap8 = miso8; capd0 = dir0; capd8 = dir8;
        #HALF;
        qspi_sclk = 1'b0;
    endtask

    task automatic send(input logic [31:0] val, input int nbits, input int n);
        logic [3:0] mo;
        for (int i = nbits - n; i >= 0; i -= n) begin
            mo = 4'((val >> i) & 32'((1 << n) - 1));
            cyc(mo);
        end
    endtask

    task automatic read_data(input int ncyc, input int n);
        rx0 = '0;
        rx8 = '0;
        for (int i = 0; i < ncyc; i++) begin
            cyc(4'h0);
            if (i == 0) begin
                dfirst0 = capd0;
                dfirst8 = capd8;
            end
            rx0 = (rx0 << n) | {28'h0, lanes(cap0, n)};
            rx8 = (rx8 << n) | {28'h0, lanes(cap8, n)};
        end
    endtask

    task automatic start_frame(input logic [1:0] w);
        @(negedge clk);
        width = w;
        #HALF;
        qspi_csb = 1'b0;
        #HALF;
    endtask

    task automatic end_frame();
        #HALF;
        qspi_csb = 1'b1;
        #(2 * HALF);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++; if (miso0 !== 4'h0)      begin n_fail++; $display("FAIL reset_miso: got %h want 0", miso0); end
        n_tests++; if (dir0 !== 4'h0)       begin n_fail++; $display("FAIL reset_dir: got %h want 0", dir0); end
        n_tests++; if (cmd0 !== 8'h00)      begin n_fail++; $display("FAIL reset_cmd: got %h want 00", cmd0); end
        n_tests++; if (addr0 !== 24'h0)     begin n_fail++; $display("FAIL reset_addr: got %h want 000000", addr0); end
        n_tests++; if (hdr_vld0 !== 1'b0)   begin n_fail++; $display("FAIL reset_hdr_vld: got %b want 0", hdr_vld0); end
        n_tests++; if (rd_req0 !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_req: got %b want 0", rd_req0); end
        n_tests++; if (underrun0 !== 1'b0)  begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun0); end
        n_tests++; if (busy0 !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_tests++; if (busy8 !== 1'b0)      begin n_fail++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    endtask

    task automatic test_x1_read();
        int h;
        fifo0[0] = 8'hA5; fifo0[1] = 8'h3C; base0 = req0; len0 = 2; h = hdr0;
        start_frame(2'd0);
        send(32'h03, 8, 1);
        send(32'h000102, 24, 1);
        read_data(16, 1);
        end_frame();
        n_tests++; if (cmd0 !== 8'h03)        begin n_fail++; $display("FAIL x1_cmd: got %h want 03", cmd0); end
        n_tests++; if (addr0 !== 24'h000102)  begin n_fail++; $display("FAIL x1_addr: got %h want 000102", addr0); end
        n_tests++; if (hdr0 - h !== 1)        begin n_fail++; $display("FAIL x1_hdr_vld_count: got %0d want 1", hdr0 - h); end
        n_tests++; if (rx0[15:0] !== 16'hA53C) begin n_fail++; $display("FAIL x1_data: got %h want a53c", rx0[15:0]); end
        n_tests++; if (dfirst0 !== 4'b0010)   begin n_fail++; $display("FAIL x1_dir: got %b want 0010", dfirst0); end
        n_tests++; if (req0 - base0 !== 2)    begin n_fail++; $display("FAIL x1_rd_req_count: got %0d want 2", req0 - base0); end
    endtask

    task automatic test_x4_dummy();
        int h;
        fifo8[0] = 8'h5A; base8 = req8; len8 = 1; h = hdr8;
        start_frame(2'd2);
        send(32'hEB, 8, 4);
        send(32'h123456, 24, 4);
        for (int i = 0; i < 8; i++) cyc(4'h0);
        n_tests++; if (capd8 !== 4'h0)        begin n_fail++; $display("FAIL x4_dir_in_dummy: got %h want 0", capd8); end
        read_data(2, 4);
        end_frame();
        n_tests++; if (dfirst8 !== 4'hF)      begin n_fail++; $display("FAIL x4_dir: got %h want f", dfirst8); end
        n_tests++; if (rx8[7:0] !== 8'h5A)    begin n_fail++; $display("FAIL x4_data: got %h want 5a", rx8[7:0]); end
        n_tests++; if (req8 - base8 !== 1)    begin n_fail++; $display("FAIL x4_rd_req_count: got %0d want 1", req8 - base8); end
        n_tests++; if (hdr8 - h !== 1)        begin n_fail++; $display("FAIL x4_hdr_vld_count: got %0d want 1", hdr8 - h); end
        n_tests++; if (cmd8 !== 8'hEB)        begin n_fail++; $display("FAIL x4_cmd: got %h want eb", cmd8); end
        n_tests++; if (addr8 !== 24'h123456)  begin n_fail++; $display("FAIL x4_addr: got %h want 123456", addr8); end
    endtask

    task automatic test_underrun();
        base0 = req0; len0 = 0;
        start_frame(2'd1);
        n_tests++; if (underrun0 !== 1'b0)    begin n_fail++; $display("FAIL ur_clear_at_start: got %b want 0", underrun0); end
        send(32'h3B, 8, 2);
        send(32'h000010, 24, 2);
        read_data(4, 2);
        end_frame();
        n_tests++; if (rx0[7:0] !== 8'hFF)    begin n_fail++; $display("FAIL ur_data: got %h want ff", rx0[7:0]); end
        n_tests++; if (underrun0 !== 1'b1)    begin n_fail++; $display("FAIL ur_flag: got %b want 1", underrun0); end
        n_tests++; if (req0 - base0 !== 0)    begin n_fail++; $display("FAIL ur_rd_req_count: got %0d want 0", req0 - base0); end
        qspi_csb = 1'b0;
        #HALF;
        n_tests++; if (underrun0 !== 1'b0)    begin n_fail++; $display("FAIL ur_clear_next_frame: got %b want 1->0", underrun0); end
        qspi_csb = 1'b1;
        #(2 * HALF);
    endtask

    task automatic test_abort_data();
        int k;
        fifo0[0] = 8'hC3; fifo0[1] = 8'h99; base0 = req0; len0 = 2;
        start_frame(2'd0);
        send(32'h0B, 8, 1);
        send(32'hABCDEF, 24, 1);
        read_data(3, 1);
        #HALF;
        qspi_csb = 1'b1;
        k = 0;
        while (dir0 !== 4'h0 && k < 4) begin
            @(negedge clk);
            k++;
        end
        n_tests++; if (dir0 !== 4'h0)         begin n_fail++; $display("FAIL abort_dir_release: got %h want 0 within 4 clks", dir0); end
        n_tests++; if (rx0[2:0] !== 3'b110)   begin n_fail++; $display("FAIL abort_partial_bits: got %b want 110", rx0[2:0]); end
        repeat (20) @(negedge clk);
        n_tests++; if (busy0 !== 1'b0)        begin n_fail++; $display("FAIL abort_idle: got busy %b want 0", busy0); end
        for (int i = 0; i < 4; i++) cyc(4'hF);   // sclk with csb high
        n_tests++; if (req0 - base0 !== 1)    begin n_fail++; $display("FAIL abort_rd_req_count: got %0d want 1", req0 - base0); end
        n_tests++; if (miso0 !== 4'h0)        begin n_fail++; $display("FAIL abort_miso_quiet: got %h want 0", miso0); end
        n_tests++; if (cmd0 !== 8'h0B)        begin n_fail++; $display("FAIL abort_cmd: got %h want 0b", cmd0); end
        n_tests++; if (addr0 !== 24'hABCDEF)  begin n_fail++; $display("FAIL abort_addr: got %h want abcdef", addr0); end
    endtask

    task automatic test_abort_addr();
        int h;
        h = hdr0;
        start_frame(2'd0);
        send(32'h9F, 8, 1);
        send(32'h123, 12, 1);
        end_frame();
        n_tests++; if (hdr0 - h !== 0)        begin n_fail++; $display("FAIL hdr_abort_no_vld: got %0d want 0", hdr0 - h); end
        n_tests++; if (cmd0 !== 8'h0B)        begin n_fail++; $display("FAIL hdr_abort_cmd_kept: got %h want 0b", cmd0); end
        n_tests++; if (addr0 !== 24'hABCDEF)  begin n_fail++; $display("FAIL hdr_abort_addr_kept: got %h want abcdef", addr0); end
        base0 = req0; len0 = 0;
        start_frame(2'd1);
        send(32'h6B, 8, 2);
        send(32'h00FF00, 24, 2);
        end_frame();
        n_tests++; if (cmd0 !== 8'h6B)        begin n_fail++; $display("FAIL hdr_after_abort_cmd: got %h want 6b", cmd0); end
        n_tests++; if (addr0 !== 24'h00FF00)  begin n_fail++; $display("FAIL hdr_after_abort_addr: got %h want 00ff00", addr0); end
        n_tests++; if (hdr0 - h !== 1)        begin n_fail++; $display("FAIL hdr_after_abort_vld: got %0d want 1", hdr0 - h); end
    endtask

    task automatic test_reset_mid();
        int h, r;
        fifo0[0] = 8'h81; base0 = req0; len0 = 1;
        start_frame(2'd0);
        send(32'h03, 8, 1);
        send(32'h000000, 24, 1);
        read_data(3, 1);
        n_tests++; if (dir0 !== 4'b0010)      begin n_fail++; $display("FAIL rmid_dir_before: got %b want 0010", dir0); end
        rstn = 1'b0;
        #1;
        n_tests++; if (miso0 !== 4'h0)        begin n_fail++; $display("FAIL rmid_miso: got %h want 0", miso0); end
        n_tests++; if (dir0 !== 4'h0)         begin n_fail++; $display("FAIL rmid_dir: got %h want 0", dir0); end
        n_tests++; if (cmd0 !== 8'h00)        begin n_fail++; $display("FAIL rmid_cmd: got %h want 00", cmd0); end
        n_tests++; if (addr0 !== 24'h0)       begin n_fail++; $display("FAIL rmid_addr: got %h want 000000", addr0); end
        n_tests++; if (hdr_vld0 !== 1'b0)     begin n_fail++; $display("FAIL rmid_hdr_vld: got %b want 0", hdr_vld0); end
        n_tests++; if (rd_req0 !== 1'b0)      begin n_fail++; $display("FAIL rmid_rd_req: got %b want 0", rd_req0); end
        n_tests++; if (underrun0 !== 1'b0)    begin n_fail++; $display("FAIL rmid_underrun: got %b want 0", underrun0); end
        n_tests++; if (busy0 !== 1'b0)        begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy0); end
        #9;
        rstn = 1'b1;
        h = hdr0; r = req0;
        // csb still low: a full header's worth of clocks must do nothing.
        send(32'h5A5A5A5A, 32, 1);
        read_data(8, 1);
        n_tests++; if (busy0 !== 1'b0)        begin n_fail++; $display("FAIL rmid_ignore_busy: got %b want 0", busy0); end
        n_tests++; if (rx0[7:0] !== 8'h00)    begin n_fail++; $display("FAIL rmid_ignore_miso: got %h want 00", rx0[7:0]); end
        n_tests++; if (hdr0 - h !== 0)        begin n_fail++; $display("FAIL rmid_ignore_hdr: got %0d want 0", hdr0 - h); end
        n_tests++; if (req0 - r !== 0)        begin n_fail++; $display("FAIL rmid_ignore_rd_req: got %0d want 0", req0 - r); end
        end_frame();
        start_frame(2'd0);
        send(32'h05, 8, 1);
        send(32'h00A0A0, 24, 1);
        end_frame();
        n_tests++; if (cmd0 !== 8'h05)        begin n_fail++; $display("FAIL rmid_new_cmd: got %h want 05", cmd0); end
        n_tests++; if (addr0 !== 24'h00A0A0)  begin n_fail++; $display("FAIL rmid_new_addr: got %h want 00a0a0", addr0); end
        n_tests++; if (hdr0 - h !== 1)        begin n_fail++; $display("FAIL rmid_new_hdr: got %0d want 1", hdr0 - h); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_x1_read();
        test_x4_dummy();
        test_underrun();
        test_abort_data();
        test_abort_addr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
